// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered digit store,
// one digit per slot with leading dead-time blanking, registered pin outputs.
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [2:0]      wr_idx,
    input  logic [3:0]      wr_data,
    input  logic            wr_dp,
    input  logic            wr_commit,
    input  logic [NDIG-1:0] en_mask,
    input  logic [6:0]      seg_in,
    output logic [3:0]      digit_out,
    output logic [7:0]      seg_out,
    output logic [NDIG-1:0] an_n,
    output logic            frame_tick,
    output logic            commit_pending
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [2:0]    IDX_MAX = 3'(NDIG - 1);
    localparam logic [3:0]    NDIG_C  = 4'(NDIG);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [4:0]      r_shadow [8];
    logic [4:0]      r_active [8];
    logic            r_pending;
    logic [3:0]      r_digit;
    logic [7:0]      r_seg;
    logic [NDIG-1:0] r_an;
    logic            r_tick;

    logic            w_slot_end;
    logic            w_frame_edge;
    logic            w_copy;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      w_idx_nxt;
    logic [4:0]      w_cur;
    logic [NDIG-1:0] w_sel;
    logic            w_en_bit;
    logic [3:0]      w_digit_nxt;
    logic [7:0]      w_seg_nxt;
    logic [NDIG-1:0] w_an_nxt;
    logic            w_tick_nxt;
    logic            w_pending_nxt;

    always_comb begin
        w_slot_end   = (r_cnt == CNT_MAX);
        w_frame_edge = w_slot_end && (r_idx == IDX_MAX);
        w_copy       = w_frame_edge && r_pending;
        w_cnt_nxt    = w_slot_end ? '0 : r_cnt + 1'b1;
        if (w_frame_edge)
            w_idx_nxt = '0;
        else if (w_slot_end)
            w_idx_nxt = r_idx + 3'd1;
        else
            w_idx_nxt = r_idx;

        w_state_nxt = r_state;
        case (r_state)
            ST_BLANK: if (w_cnt_nxt >= BLANK_C) w_state_nxt = ST_ON;
            ST_ON:    if (w_slot_end) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_BLANK;
        endcase

        // Slot 0 after a copy must show the incoming shadow value, not stale active.
        w_cur    = w_copy ? r_shadow[w_idx_nxt] : r_active[w_idx_nxt];
        w_sel    = NDIG'(1) << w_idx_nxt;
        w_en_bit = |(w_sel & en_mask);

        w_digit_nxt = (w_cnt_nxt == '0) ? w_cur[3:0] : r_digit;
        w_an_nxt    = '1;
        w_seg_nxt   = '0;
        if (w_state_nxt == ST_ON) begin
            w_an_nxt = ~(w_sel & en_mask);
            if (w_en_bit)
                w_seg_nxt = {seg_in, w_cur[4]};
        end

        w_tick_nxt    = (w_cnt_nxt == '0) && (w_idx_nxt == '0);
        w_pending_nxt = w_copy ? wr_commit : (r_pending | wr_commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_BLANK;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shadow  <= '{default: '0};
            r_active  <= '{default: '0};
            r_pending <= 1'b0;
            r_digit   <= '0;
            r_seg     <= '0;
            r_an      <= '1;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_digit   <= w_digit_nxt;
            r_seg     <= w_seg_nxt;
            r_an      <= w_an_nxt;
            r_tick    <= w_tick_nxt;
            if (w_copy)
                r_active <= r_shadow;
            if (wr_en && ({1'b0, wr_idx} < NDIG_C))
                r_shadow[wr_idx] <= {wr_dp, wr_data};
        end
    end

    assign digit_out      = r_digit;
    assign seg_out        = r_seg;
    assign an_n           = r_an;
    assign frame_tick     = r_tick;
    assign commit_pending = r_pending;

endmodule
